// File: rtl/cpu_pkg.sv
// Shared encodings for the lab CPU control path.
// States, opcode/op fields, ALU ops and writeback selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    GET_A     = 3'd2,
    GET_B     = 3'd3,
    CALC      = 3'd4,
    WRITE_REG = 3'd5,
    WRITE_IMM = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b01;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

endpackage

// File: rtl/cpu_fsm_instr_dec.sv
// Instruction field splitter and immediate sign extension.
// Pure combinational; fields are valid in every state.
module instr_dec (
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  shift,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign shift  = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_fsm.sv
// Instruction register and control sequencer for the lab CPU.
// Define CPU_FSM_ERR_EN to add a sticky err output for bad opcodes.
module cpu_fsm
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
`ifdef CPU_FSM_ERR_EN
  output logic [15:0] sximm8,
  output logic        err
`else
  output logic [15:0] sximm8
`endif
);

  state_t      state, state_n;
  logic [15:0] ir;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op;
  logic        is_mov_imm, is_mov_reg, is_alu;

  instr_dec u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .shift  (shift),
    .sximm5 (sximm5),
    .sximm8 (sximm8)
  );

  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign is_alu     = (opcode == OPC_ALU);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT;
    else       state <= state_n;
  end

  // IR only accepts a new word while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       ir <= '0;
    else if (load && state == WAIT)  ir <= in;
  end

`ifdef CPU_FSM_ERR_EN
  logic undef_op;
  assign undef_op = ~(is_mov_imm | is_mov_reg | is_alu);

  // Sticky flag for undefined instructions seen in DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err <= 1'b0;
    else if (state == DECODE && undef_op) err <= 1'b1;
  end
`endif

  // Next state and Moore outputs
  always_comb begin
    state_n  = state;
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    vsel     = VSEL_MDATA;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = ALU_ADD;
    case (state)
      WAIT: begin
        w = 1'b1;
        if (s) state_n = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_mov_imm: state_n = WRITE_IMM;
          is_mov_reg: state_n = GET_B;
          is_alu:     state_n = GET_A;
          default:    state_n = WAIT;
        endcase
      end
      GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_n = GET_B;
      end
      GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_n = CALC;
      end
      CALC: begin
        if (is_mov_reg) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else begin
          ALUop = op;
        end
        if (is_alu && op == OP_CMP) begin
          loads   = 1'b1;
          state_n = WAIT;
        end else begin
          loadc   = 1'b1;
          state_n = WRITE_REG;
        end
      end
      WRITE_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_n  = WAIT;
      end
      WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_n  = WAIT;
      end
      default: state_n = WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_fsm.sv
// Directed bench for cpu_fsm.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cpu_fsm;

  logic        clk = 1'b0;
  logic        reset, load, s;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;
`ifdef CPU_FSM_ERR_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm5   (sximm5),
`ifdef CPU_FSM_ERR_EN
    .sximm8   (sximm8),
    .err      (err)
`else
    .sximm8   (sximm8)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load an instruction while idle, then pulse s for one edge.
  task automatic issue(input logic [15:0] instr);
    in = instr; load = 1'b1;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    s = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
    tick(); tick();
    n_cmp++; if (w !== 1'b1) begin n_bad++;
      $display("FAIL rst_w got %b want 1", w); end
    n_cmp++; if (sximm8 !== 16'h0000) begin n_bad++;
      $display("FAIL rst_ir got %h want 0000", sximm8); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int wr;
    issue(16'hA148);
    tick();
    tick();
    n_cmp++; if (loadb !== 1'b1) begin n_bad++;
      $display("FAIL rm_in_getb got %b want 1", loadb); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({w, loadb, write} !== 3'b100) begin n_bad++;
      $display("FAIL rm_async got %b want 100", {w, loadb, write}); end
    tick();
    reset = 1'b0;
    wr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (w !== 1'b1 || write !== 1'b0) wr++;
    end
    n_cmp++; if (wr !== 0) begin n_bad++;
      $display("FAIL rm_idle got %0d bad cycles want 0", wr); end
  endtask

  task automatic test_mov_imm();
    issue(16'hD0FB);
    n_cmp++; if (w !== 1'b0) begin n_bad++;
      $display("FAIL movi_busy got %b want 0", w); end
    tick();
    n_cmp++;
    if ({write, writenum, vsel} !== {1'b1, 3'd0, 2'b10}) begin n_bad++;
      $display("FAIL movi_wr got %b want 1_000_10",
               {write, writenum, vsel}); end
    n_cmp++; if (sximm8 !== 16'hFFFB) begin n_bad++;
      $display("FAIL movi_imm got %h want fffb", sximm8); end
    tick();
    n_cmp++; if ({w, write} !== 2'b10) begin n_bad++;
      $display("FAIL movi_done got %b want 10", {w, write}); end
  endtask

  task automatic test_add();
    issue(16'hA148);
    tick();
    n_cmp++; if ({readnum, loada} !== {3'd1, 1'b1}) begin n_bad++;
      $display("FAIL add_geta got %b want 001_1", {readnum, loada}); end
    tick();
    n_cmp++;
    if ({readnum, loadb, loada} !== {3'd0, 1'b1, 1'b0}) begin n_bad++;
      $display("FAIL add_getb got %b want 000_1_0",
               {readnum, loadb, loada}); end
    tick();
    n_cmp++;
    if ({ALUop, asel, bsel, shift, loadc, loads} !== 8'b00_0_0_01_1_0)
    begin n_bad++;
      $display("FAIL add_calc got %b want 00000110",
               {ALUop, asel, bsel, shift, loadc, loads}); end
    tick();
    n_cmp++;
    if ({writenum, vsel, write} !== {3'd2, 2'b11, 1'b1}) begin n_bad++;
      $display("FAIL add_wr got %b want 010_11_1",
               {writenum, vsel, write}); end
    tick();
    n_cmp++; if ({w, write} !== 2'b10) begin n_bad++;
      $display("FAIL add_done got %b want 10", {w, write}); end
  endtask

  task automatic test_cmp();
    int wr;
    wr = 0;
    issue(16'hA900);
    if (write) wr++;
    tick(); if (write) wr++;
    tick(); if (write) wr++;
    tick(); if (write) wr++;
    n_cmp++; if ({ALUop, loads, loadc} !== 4'b01_1_0) begin n_bad++;
      $display("FAIL cmp_calc got %b want 0110", {ALUop, loads, loadc}); end
    tick();
    n_cmp++; if (wr !== 0) begin n_bad++;
      $display("FAIL cmp_nowr got %0d writes want 0", wr); end
    n_cmp++; if ({w, write} !== 2'b10) begin n_bad++;
      $display("FAIL cmp_done got %b want 10", {w, write}); end
  endtask

  task automatic test_mov_reg();
    int la;
    la = 0;
    issue(16'hC075);
    if (loada) la++;
    tick(); if (loada) la++;
    n_cmp++; if ({readnum, loadb} !== {3'd5, 1'b1}) begin n_bad++;
      $display("FAIL movr_getb got %b want 101_1", {readnum, loadb}); end
    tick(); if (loada) la++;
    n_cmp++;
    if ({asel, shift, ALUop, loadc} !== {1'b1, 2'b10, 2'b00, 1'b1})
    begin n_bad++;
      $display("FAIL movr_calc got %b want 1_10_00_1",
               {asel, shift, ALUop, loadc}); end
    tick(); if (loada) la++;
    n_cmp++;
    if ({writenum, vsel, write} !== {3'd3, 2'b11, 1'b1}) begin n_bad++;
      $display("FAIL movr_wr got %b want 011_11_1",
               {writenum, vsel, write}); end
    n_cmp++; if (la !== 0) begin n_bad++;
      $display("FAIL movr_noa got %0d loada pulses want 0", la); end
    tick();
  endtask

  task automatic test_load_ignored();
    issue(16'hA148);
    tick();
    in = 16'hD0FF; load = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++; if (sximm8 !== 16'h0048) begin n_bad++;
      $display("FAIL ldign_ir got %h want 0048", sximm8); end
    tick();
    tick();
    n_cmp++; if ({writenum, write} !== {3'd2, 1'b1}) begin n_bad++;
      $display("FAIL ldign_wr got %b want 010_1", {writenum, write}); end
    tick();
  endtask

  task automatic test_undef();
    int wr;
    wr = 0;
    issue(16'hE000);
    n_cmp++; if (w !== 1'b0) begin n_bad++;
      $display("FAIL und_dec got %b want 0", w); end
    if (write) wr++;
    tick();
    n_cmp++; if ({w, write, wr[0]} !== 3'b100) begin n_bad++;
      $display("FAIL und_done got %b want 100", {w, write, wr[0]}); end
`ifdef CPU_FSM_ERR_EN
    n_cmp++; if (err !== 1'b1) begin n_bad++;
      $display("FAIL und_err got %b want 1", err); end
`endif
  endtask

  task automatic test_back_to_back();
    int wr;
    wr = 0;
    in = 16'hD3FF; load = 1'b1;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    if (write) wr++;
    tick();
    if (write) wr++;
    n_cmp++; if (writenum !== 3'd3) begin n_bad++;
      $display("FAIL b2b_rn got %0d want 3", writenum); end
    tick();
    n_cmp++; if ({w, write} !== 2'b10) begin n_bad++;
      $display("FAIL b2b_wait got %b want 10", {w, write}); end
    tick();
    n_cmp++; if (w !== 1'b0) begin n_bad++;
      $display("FAIL b2b_restart got %b want 0", w); end
    s = 1'b0;
    n_cmp++; if (wr !== 1) begin n_bad++;
      $display("FAIL b2b_onewr got %0d writes want 1", wr); end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mov_reg();
    test_load_ignored();
    test_undef();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
